traffic_light_v2: RTL
=====================

TRAFFIC_LIGHT_V2 -- requirements
Module: traffic_light_v2

Interface
REQ-001 Parameter N, default 11: timer width in bits.
REQ-002 Parameter T_LONG, default 25: long-interval length in cycles (main green minimum, side green maximum).
REQ-003 Parameter T_SHORT, default 4: short-interval length in cycles (yellow, side green minimum, flash half-period).
REQ-004 Parameter T_ALLRED, default 2: all-red clearance length in cycles.
REQ-005 Parameters shall satisfy 1 <= T_SHORT, T_ALLRED, T_LONG <= 2^N-1; other values are unsupported.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 c  input  1  side-road (farm) vehicle sensor, 1 = vehicle waiting.
REQ-009 flash  input  1  night/fault flash-mode request, 1 = flash.
REQ-010 Timing  output  N  current state-timer value.
REQ-011 TL_o  output  1  long interval elapsed: Timing >= T_LONG-1.
REQ-012 TS_o  output  1  short interval elapsed: Timing >= T_SHORT-1.
REQ-013 HG, HY, HR  output  1 each  highway green/yellow/red lamps.
REQ-014 FG, FY, FR  output  1 each  farm green/yellow/red lamps.
REQ-015 ST_o  output  3  state encoding per REQ-017.

Function
REQ-016 Timer shall clear to 0 on every state entry, increment by 1 each cycle otherwise, saturating at 2^N-1 (no wrap).
REQ-017 States: HGRN=0, HYEL=1, ARED1=2, FGRN=3, FYEL=4, ARED2=5, FLASH=6; code 7 shall recover to HGRN next cycle.
REQ-018 HGRN -> HYEL when flash=1, or when TL_o=1 and c=1; otherwise hold.
REQ-019 HYEL -> ARED1 when TS_o=1 (flash does not shorten yellow).
REQ-020 ARED1 -> FLASH when Timing >= T_ALLRED-1 and flash=1; -> FGRN when Timing >= T_ALLRED-1 and flash=0.
REQ-021 FGRN -> FYEL when flash=1, or TL_o=1, or (c=0 and TS_o=1).
REQ-022 FYEL -> ARED2 when TS_o=1.
REQ-023 ARED2 -> FLASH when Timing >= T_ALLRED-1 and flash=1; -> HGRN when Timing >= T_ALLRED-1 and flash=0.
REQ-024 FLASH -> ARED2 when flash=0 (timer cleared); otherwise hold.
REQ-025 Flash shall take priority over c in every state.
REQ-026 In FLASH a blink bit shall be 1 on entry and toggle whenever TS_o=1, the timer clearing to 0 at each toggle.
REQ-027 Lamp decode (combinational from state, blink): HGRN HG,FR; HYEL HY,FR; ARED1/ARED2 HR,FR; FGRN HR,FG; FYEL HR,FY; FLASH HY=FR=blink, all others 0.
REQ-028 Never shall a green or yellow be lit on both roads simultaneously; at most one lamp per road shall be lit.
REQ-029 Transitions shall take effect at the clock edge where the condition holds; lamp outputs change in that same cycle (no extra latency).

Reset
REQ-030 reset=0 shall immediately force state HGRN, Timing=0, blink=0: HG=1, FR=1, all other lamps 0, TL_o=TS_o=0, ST_o=0, from any state including mid-interval.
REQ-031 On reset release, operation shall begin from HGRN with Timing=0 at the first rising edge.

Verification (bench parameters N=4, T_LONG=8, T_SHORT=3, T_ALLRED=2)
REQ-032 Assert reset=0 in any state -> HG=1, FR=1, ST_o=0, Timing=0 without a clock edge.
REQ-033 c=0, flash=0 for 30 cycles -> stays HGRN, Timing counts 0..15 then holds 15; TL_o=1 from Timing=7.
REQ-034 c=1 held from release -> HG 8 cycles, HY 3, HR/FR 2, FG 8, FY 3, HR/FR 2, HG again (full cycle 26).
REQ-035 In FGRN drop c at Timing=5 -> FYEL next edge; drop c at Timing=0 -> FGRN holds until Timing=2, then FYEL.
REQ-036 flash=1 in HGRN at Timing=2 -> HYEL next edge, 3 cycles, ARED1 2, FLASH; HY=FR toggle every 3 cycles starting 1; flash=0 -> ARED2 2 cycles -> HGRN.
REQ-037 Force c=1 and flash=1 together in HGRN at Timing=7 -> path via HYEL/ARED1 to FLASH, FG never asserted; overlap checker REQ-028 active throughout.

Source files
------------

// File: rtl/traffic_light_v2.sv
// Highway / farm-road intersection controller with all-red clearance and a
// night flash mode; one state timer shared by every interval.
module traffic_light_v2 #(
  parameter int N        = 11,
  parameter int T_LONG   = 25,
  parameter int T_SHORT  = 4,
  parameter int T_ALLRED = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c,
  input  logic         flash,
  output logic [N-1:0] Timing,
  output logic         TL_o,
  output logic         TS_o,
  output logic         HG,
  output logic         HY,
  output logic         HR,
  output logic         FG,
  output logic         FY,
  output logic         FR,
  output logic [2:0]   ST_o
);

  typedef enum logic [2:0] {
    HGRN  = 3'd0,
    HYEL  = 3'd1,
    ARED1 = 3'd2,
    FGRN  = 3'd3,
    FYEL  = 3'd4,
    ARED2 = 3'd5,
    FLASH = 3'd6,
    BAD   = 3'd7
  } state_t;

  localparam logic [N-1:0] L_LONG  = N'(T_LONG - 1);
  localparam logic [N-1:0] L_SHORT = N'(T_SHORT - 1);
  localparam logic [N-1:0] L_ARED  = N'(T_ALLRED - 1);

  state_t       r_state;
  logic [N-1:0] r_timer;
  logic         r_blink;
  logic         w_tl;
  logic         w_ts;
  logic         w_ar;

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (v == '1) ? v : v + N'(1);
  endfunction

  assign w_tl   = (r_timer >= L_LONG);
  assign w_ts   = (r_timer >= L_SHORT);
  assign w_ar   = (r_timer >= L_ARED);
  assign Timing = r_timer;
  assign TL_o   = w_tl;
  assign TS_o   = w_ts;
  assign ST_o   = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HGRN;
      r_timer <= '0;
      r_blink <= 1'b0;
    end else begin
      r_timer <= sat_inc(r_timer);
      case (r_state)
        HGRN: if (flash || (w_tl && c)) begin
          r_state <= HYEL;
          r_timer <= '0;
        end
        HYEL: if (w_ts) begin
          r_state <= ARED1;
          r_timer <= '0;
        end
        ARED1: if (w_ar) begin
          r_state <= flash ? FLASH : FGRN;
          r_timer <= '0;
          r_blink <= 1'b1;
        end
        FGRN: if (flash || w_tl || (!c && w_ts)) begin
          r_state <= FYEL;
          r_timer <= '0;
        end
        FYEL: if (w_ts) begin
          r_state <= ARED2;
          r_timer <= '0;
        end
        ARED2: if (w_ar) begin
          r_state <= flash ? FLASH : HGRN;
          r_timer <= '0;
          r_blink <= 1'b1;
        end
        // Each flash half-period restarts the timer so TS_o paces the blink.
        FLASH: if (!flash) begin
          r_state <= ARED2;
          r_timer <= '0;
        end else if (w_ts) begin
          r_blink <= ~r_blink;
          r_timer <= '0;
        end
        default: begin
          r_state <= HGRN;
          r_timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    HG = 1'b0;
    HY = 1'b0;
    HR = 1'b0;
    FG = 1'b0;
    FY = 1'b0;
    FR = 1'b0;
    case (r_state)
      HGRN:         begin HG = 1'b1; FR = 1'b1; end
      HYEL:         begin HY = 1'b1; FR = 1'b1; end
      ARED1, ARED2: begin HR = 1'b1; FR = 1'b1; end
      FGRN:         begin HR = 1'b1; FG = 1'b1; end
      FYEL:         begin HR = 1'b1; FY = 1'b1; end
      FLASH:        begin HY = r_blink; FR = r_blink; end
      default:      ;
    endcase
  end

endmodule
